ex_stage_md: RTL and testbench

//  Parametrised execute stage for the RV32 pipeline: operand-B mux, full RV32I ALU plus
//  RV32M multiply/divide, and the EX/MEM pipeline register. Sits between ID/EX and MEM.

---
 rtl/ex_stage_md_pkg.sv | 31 +++
 rtl/ex_stage_md_if.sv | 38 +++
 rtl/ex_stage_md_muldiv.sv | 126 ++++++++++++
 rtl/ex_stage_md.sv | 148 ++++++++++++++
 tb/tb_ex_stage_md.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_md_pkg.sv
// Shared definitions for the RV32 execute stage: ALU op encoding and MUL/DIV FSM states.
package ex_stage_md_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX -> EX -> MEM handshake bundle; master is the surrounding pipeline, slave is the EX stage.
interface ex_stage_md_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [3:0]        alu_op;
    logic              src_b_sel;
    logic [RD_W-1:0]   rd_ex;
    logic [XLEN-1:0]   r_data1;
    logic [XLEN-1:0]   r_data2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc4_ex;
    logic              flush;
    logic              mem_ready;
    logic              mem_valid;
    logic [CTRL_W-1:0] ctrl_mem;
    logic [RD_W-1:0]   rd_mem;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc4_mem;
    logic              md_busy;

    modport master (
        output in_valid, ctrl_ex, alu_op, src_b_sel, rd_ex, r_data1, r_data2, imm, pc4_ex,
               flush, mem_ready,
        input  in_ready, mem_valid, ctrl_mem, rd_mem, alu_result, write_data, pc4_mem, md_busy
    );

    modport slave (
        input  in_valid, ctrl_ex, alu_op, src_b_sel, rd_ex, r_data1, r_data2, imm, pc4_ex,
               flush, mem_ready,
        output in_ready, mem_valid, ctrl_mem, rd_mem, alu_result, write_data, pc4_mem, md_busy
    );
endinterface

// File: rtl/ex_stage_md_muldiv.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider on operand magnitudes,
// with sign fixup at the output. Fixed XLEN-cycle latency; o_last flags the final iteration.
module ex_stage_md_muldiv
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_result
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic              r_a_neg;
    logic              r_b_neg;
    logic              r_b_zero;
    logic [XLEN-1:0]   r_a_raw;
    logic [XLEN-1:0]   r_m;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_start_div;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_is_div;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    // MUL low bits are sign-agnostic, so only the unsigned divides skip magnitude conversion
    assign w_start_div = i_op >= OP_DIV;
    assign w_signed    = (i_op != OP_DIVU) && (i_op != OP_REMU);
    assign w_a_neg     = w_signed & i_a[XLEN-1];
    assign w_b_neg     = w_signed & i_b[XLEN-1];
    assign w_mag_a     = w_a_neg ? -i_a : i_a;
    assign w_mag_b     = w_b_neg ? -i_b : i_b;

    assign w_is_div = r_op >= OP_DIV;
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shift  = {r_hi, r_lo[XLEN-1]};
    assign w_trial  = w_shift - {1'b0, r_m};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_raw  <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_op     <= i_op;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (i_b == '0);
            r_a_raw  <= i_a;
            r_m      <= w_start_div ? w_mag_b : w_mag_a;
            r_lo     <= w_start_div ? w_mag_a : w_mag_b;
            r_hi     <= '0;
        end else if (r_active) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
                r_active <= 1'b0;
            end
            if (w_is_div) begin
                // trial subtraction: keep it when the partial remainder stays non-negative
                if (!w_trial[XLEN]) begin
                    r_hi <= w_trial[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign o_last = r_active & (r_cnt == CNT_LAST);

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
    assign w_quot   = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
    assign w_rem    = r_a_neg ? -r_hi : r_hi;

    // Divide by zero bypasses the sign fixup: all-ones quotient, dividend as remainder
    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:           o_result = w_prod_s[XLEN-1:0];
            OP_MULH:          o_result = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:  o_result = r_b_zero ? '1 : w_quot;
            OP_REM, OP_REMU:  o_result = r_b_zero ? r_a_raw : w_rem;
            default:          o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_md.sv
// RV32IM execute stage: operand-B mux, single-cycle ALU, iterative MUL/DIV with upstream
// stall, and the EX/MEM register with valid, MEM backpressure and flush.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    ex_stage_md_if.slave  bus
);
    localparam int SH_W = $clog2(XLEN);

    state_t            r_state;
    logic              r_mem_valid;
    logic [CTRL_W-1:0] r_ctrl_mem;
    logic [RD_W-1:0]   r_rd_mem;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_write_data;
    logic [XLEN-1:0]   r_pc4_mem;
    logic [CTRL_W-1:0] r_ctrl_l;
    logic [RD_W-1:0]   r_rd_l;
    logic [XLEN-1:0]   r_wd_l;
    logic [XLEN-1:0]   r_pc4_l;

    logic              w_mem_free;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_md;
    logic              w_md_start;
    logic              w_load_alu;
    logic              w_load_md;
    logic [XLEN-1:0]   w_opb;
    logic [SH_W-1:0]   w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic              w_md_last;
    logic [XLEN-1:0]   w_md_result;

    assign w_mem_free = !r_mem_valid | bus.mem_ready;
    assign w_in_ready = !reset & (r_state == S_IDLE) & w_mem_free;
    // flush wins over a same-cycle accept
    assign w_accept   = bus.in_valid & w_in_ready & !bus.flush;
    assign w_is_md    = is_muldiv(bus.alu_op);
    assign w_md_start = w_accept & w_is_md;
    assign w_load_alu = w_accept & !w_is_md;
    assign w_load_md  = (r_state == S_DONE) & w_mem_free & !bus.flush;

    assign w_opb   = bus.src_b_sel ? bus.imm : bus.r_data2;
    assign w_shamt = w_opb[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.alu_op)
            OP_ADD:  w_alu = bus.r_data1 + w_opb;
            OP_SUB:  w_alu = bus.r_data1 - w_opb;
            OP_AND:  w_alu = bus.r_data1 & w_opb;
            OP_OR:   w_alu = bus.r_data1 | w_opb;
            OP_XOR:  w_alu = bus.r_data1 ^ w_opb;
            OP_SLL:  w_alu = bus.r_data1 << w_shamt;
            OP_SRL:  w_alu = bus.r_data1 >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(bus.r_data1) >>> w_shamt);
            OP_SLT:  w_alu = XLEN'($signed(bus.r_data1) < $signed(w_opb));
            OP_SLTU: w_alu = XLEN'(bus.r_data1 < w_opb);
            default: w_alu = '0;
        endcase
    end

    ex_stage_md_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_md_start),
        .i_abort  (bus.flush),
        .i_op     (bus.alu_op),
        .i_a      (bus.r_data1),
        .i_b      (w_opb),
        .o_last   (w_md_last),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_md_start) r_state <= S_BUSY;
                S_BUSY:  if (w_md_last)  r_state <= S_DONE;
                S_DONE:  if (w_mem_free) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sideband fields of a MUL/DIV are captured at accept; upstream may move on while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_l <= '0;
            r_rd_l   <= '0;
            r_wd_l   <= '0;
            r_pc4_l  <= '0;
        end else if (w_md_start) begin
            r_ctrl_l <= bus.ctrl_ex;
            r_rd_l   <= bus.rd_ex;
            r_wd_l   <= bus.r_data2;
            r_pc4_l  <= bus.pc4_ex;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_valid  <= 1'b0;
            r_ctrl_mem   <= '0;
            r_rd_mem     <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc4_mem    <= '0;
        end else if (w_load_alu) begin
            r_mem_valid  <= 1'b1;
            r_ctrl_mem   <= bus.ctrl_ex;
            r_rd_mem     <= bus.rd_ex;
            r_alu_result <= w_alu;
            r_write_data <= bus.r_data2;
            r_pc4_mem    <= bus.pc4_ex;
        end else if (w_load_md) begin
            r_mem_valid  <= 1'b1;
            r_ctrl_mem   <= r_ctrl_l;
            r_rd_mem     <= r_rd_l;
            r_alu_result <= w_md_result;
            r_write_data <= r_wd_l;
            r_pc4_mem    <= r_pc4_l;
        end else if (bus.mem_ready) begin
            r_mem_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.ctrl_mem   = r_ctrl_mem;
    assign bus.rd_mem     = r_rd_mem;
    assign bus.alu_result = r_alu_result;
    assign bus.write_data = r_write_data;
    assign bus.pc4_mem    = r_pc4_mem;
    assign bus.md_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: random and directed ALU/MUL/DIV traffic against a native-arithmetic model.
module tb_ex_stage_md;
    import ex_stage_md_pkg::*;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 5;
    localparam int RD_W   = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_stage_md_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RD_W(RD_W)) bus ();

    ex_stage_md #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int     sa;
        int     sb;
        longint p;
        logic   ovf;
        sa  = a;
        sb  = b;
        p   = longint'(sa) * longint'(sb);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'(sa >>> b[4:0]);
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:  return p[31:0];
            OP_MULH: return p[63:32];
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic sel, input logic [4:0] rd,
                         input logic [4:0] ctrl, input logic [31:0] pc4);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.r_data1   = a;
        bus.r_data2   = b;
        bus.imm       = im;
        bus.src_b_sel = sel;
        bus.rd_ex     = rd;
        bus.ctrl_ex   = ctrl;
        bus.pc4_ex    = pc4;
    endtask

    task automatic scramble_upstream();
        bus.alu_op    = 4'($urandom);
        bus.r_data1   = $urandom;
        bus.r_data2   = $urandom;
        bus.imm       = $urandom;
        bus.src_b_sel = 1'($urandom);
        bus.rd_ex     = 5'($urandom);
        bus.ctrl_ex   = 5'($urandom);
        bus.pc4_ex    = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b1;
        scramble_upstream();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); end
        n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b exp 0", bus.mem_valid); end
        n_checks++; if (bus.alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_alu_result: got %h exp 0", bus.alu_result); end
        n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b exp 0", bus.md_busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_add();
        drive(OP_ADD, 32'd5, 32'hDEAD_0001, 32'hFFFF_FFFD, 1'b1, 5'd7, 5'h15, 32'h0000_0104);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.alu_result !== 32'd2) begin n_fail++; $display("FAIL add_result: got %h exp %h", bus.alu_result, 32'd2); end
        n_checks++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL add_mem_valid: got %b exp 1", bus.mem_valid); end
        n_checks++; if (bus.rd_mem !== 5'd7) begin n_fail++; $display("FAIL add_rd: got %h exp 7", bus.rd_mem); end
        n_checks++; if (bus.ctrl_mem !== 5'h15) begin n_fail++; $display("FAIL add_ctrl: got %h exp 15", bus.ctrl_mem); end
        n_checks++; if (bus.write_data !== 32'hDEAD_0001) begin n_fail++; $display("FAIL add_wdata: got %h exp dead0001", bus.write_data); end
        n_checks++; if (bus.pc4_mem !== 32'h0000_0104) begin n_fail++; $display("FAIL add_pc4: got %h exp 104", bus.pc4_mem); end
        @(posedge clk); #1;
        n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b exp 0", bus.mem_valid); end
    endtask

    task automatic test_sra_sltu();
        logic [3:0]  t_op[3];
        logic [31:0] t_a[3];
        logic [31:0] t_b[3];
        logic [31:0] t_exp[3];
        t_op  = '{OP_SRA, OP_SLTU, OP_SLT};
        t_a   = '{32'h8000_0000, 32'd1, 32'd1};
        t_b   = '{32'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_exp = '{32'hC000_0000, 32'd1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            drive(t_op[i], t_a[i], t_b[i], $urandom, 1'b0, 5'(i + 1), 5'd0, 32'd0);
            @(posedge clk); #1;
            n_checks++; if (bus.alu_result !== t_exp[i]) begin n_fail++; $display("FAIL sra_sltu_%0d: got %h exp %h", i, bus.alu_result, t_exp[i]); end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_random();
        logic [3:0]  op;
        logic [31:0] a, b, im, exp_r;
        logic [4:0]  rd;
        logic        sel, v;
        for (int i = 0; i < 60; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = 4'($urandom_range(0, 9));
            a   = $urandom; b = $urandom; im = $urandom;
            if (i % 4 == 0) b = $urandom_range(0, 40);
            sel = 1'($urandom);
            rd  = 5'($urandom);
            drive(op, a, b, im, sel, rd, 5'($urandom), $urandom);
            bus.in_valid = v;
            exp_r = model(op, a, sel ? im : b);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_in_ready_%0d: got %b exp 1", i, bus.in_ready); end
            @(posedge clk); #1;
            n_checks++; if (bus.mem_valid !== v) begin n_fail++; $display("FAIL rnd_valid_%0d: got %b exp %b", i, bus.mem_valid, v); end
            if (v) begin
                n_checks++; if (bus.alu_result !== exp_r) begin n_fail++; $display("FAIL rnd_result_%0d op %0d: got %h exp %h", i, op, bus.alu_result, exp_r); end
                n_checks++; if (bus.rd_mem !== rd) begin n_fail++; $display("FAIL rnd_rd_%0d: got %h exp %h", i, bus.rd_mem, rd); end
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv();
        logic [3:0]  d_op[7];
        logic [31:0] d_a[7];
        logic [31:0] d_b[7];
        logic [31:0] d_exp[7];
        logic [3:0]  op;
        logic [31:0] a, b, exp_r, pc4;
        logic [4:0]  rd, ctrl;
        int          n, busy_n;
        d_op  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_MUL, OP_MULH};
        d_a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'h8000_0000, 32'hFFFF_FFFD, 32'h8000_0000};
        d_b   = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        d_exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'hFFFF_FFF1, 32'h4000_0000};
        for (int i = 0; i < 31; i++) begin
            if (i < 7) begin
                op = d_op[i]; a = d_a[i]; b = d_b[i]; exp_r = d_exp[i];
            end else begin
                op = 4'($urandom_range(10, 15));
                a  = $urandom; b = $urandom;
                if ($urandom_range(0, 7) == 0) b = 32'd0;
                if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 300);
                exp_r = model(op, a, b);
            end
            rd = 5'($urandom); ctrl = 5'($urandom); pc4 = $urandom;
            drive(op, a, b, $urandom, 1'b0, rd, ctrl, pc4);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL md_in_ready_%0d: got %b exp 1", i, bus.in_ready); end
            @(posedge clk); #1;
            n = 0; busy_n = 0;
            while (bus.mem_valid !== 1'b1 && n < 100) begin
                if (bus.in_ready === 1'b0 && bus.md_busy === 1'b1) busy_n++;
                scramble_upstream();
                @(posedge clk); #1;
                n++;
            end
            bus.in_valid = 1'b0;
            n_checks++; if (n !== XLEN + 1) begin n_fail++; $display("FAIL md_latency_%0d: got %0d exp %0d", i, n, XLEN + 1); end
            n_checks++; if (busy_n !== XLEN + 1) begin n_fail++; $display("FAIL md_stall_%0d: got %0d exp %0d", i, busy_n, XLEN + 1); end
            n_checks++; if (bus.alu_result !== exp_r) begin n_fail++; $display("FAIL md_result_%0d op %0d a %h b %h: got %h exp %h", i, op, a, b, bus.alu_result, exp_r); end
            n_checks++; if (bus.rd_mem !== rd || bus.ctrl_mem !== ctrl) begin n_fail++; $display("FAIL md_rd_ctrl_%0d: got %h/%h exp %h/%h", i, bus.rd_mem, bus.ctrl_mem, rd, ctrl); end
            n_checks++; if (bus.write_data !== b || bus.pc4_mem !== pc4) begin n_fail++; $display("FAIL md_wdata_pc4_%0d: got %h/%h exp %h/%h", i, bus.write_data, bus.pc4_mem, b, pc4); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        logic        mv_before;
        int          stray;
        drive(OP_OR, 32'h00F0_0000, 32'h0000_0A0B, 32'd0, 1'b0, 5'd3, 5'd1, 32'd8);
        @(posedge clk); #1;
        held = 32'h00F0_0A0B;
        drive(OP_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 5'd9, 5'd2, 32'd12);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        mv_before = bus.mem_valid;
        n_checks++; if (bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b exp 1", bus.md_busy); end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_md_busy: got %b exp 0", bus.md_busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.mem_valid !== mv_before) begin n_fail++; $display("FAIL flush_mem_valid: got %b exp %b", bus.mem_valid, mv_before); end
        n_checks++; if (bus.alu_result !== held) begin n_fail++; $display("FAIL flush_fields: got %h exp %h", bus.alu_result, held); end
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.mem_valid !== 1'b0) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL flush_stray_result: got %0d exp 0", stray); end
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd4, 5'd0, 32'd0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kills_alu: got %b exp 0", bus.mem_valid); end
        drive(OP_DIVU, 32'd50, 32'd5, 32'd0, 1'b0, 5'd4, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_kills_md: got %b exp 0", bus.md_busy); end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] r1, r2;
        bus.mem_ready = 1'b0;
        r1 = model(OP_SUB, 32'h1234_5678, 32'h0000_0678);
        r2 = model(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
        drive(OP_SUB, 32'h1234_5678, 32'h0000_0678, 32'd0, 1'b0, 5'd11, 5'd3, 32'h40);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.mem_valid !== 1'b1 || bus.alu_result !== r1) begin n_fail++; $display("FAIL bp_first_load: got %b/%h exp 1/%h", bus.mem_valid, bus.alu_result, r1); end
        drive(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 1'b0, 5'd12, 5'd4, 32'h44);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready_%0d: got %b exp 0", k, bus.in_ready); end
            @(posedge clk); #1;
            n_checks++; if (bus.alu_result !== r1 || bus.rd_mem !== 5'd11 || bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d: got %h/%h/%b exp %h/0b/1", k, bus.alu_result, bus.rd_mem, bus.mem_valid, r1); end
        end
        bus.mem_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.alu_result !== r2 || bus.rd_mem !== 5'd12 || bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pending_load: got %h/%h/%b exp %h/0c/1", bus.alu_result, bus.rd_mem, bus.mem_valid, r2); end
    endtask

    task automatic test_reset_mid_div();
        drive(OP_DIV, 32'hFFFF_FF00, 32'd3, 32'd0, 1'b0, 5'd5, 5'd6, 32'h80);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.md_busy !== 1'b0 || bus.mem_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy %b valid %b ready %b exp 0/0/0", bus.md_busy, bus.mem_valid, bus.in_ready); end
        n_checks++; if (bus.alu_result !== 32'd0 || bus.write_data !== 32'd0 || bus.pc4_mem !== 32'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%h/%h exp 0/0/0", bus.alu_result, bus.write_data, bus.pc4_mem); end
        n_checks++; if (bus.rd_mem !== 5'd0 || bus.ctrl_mem !== 5'd0) begin n_fail++; $display("FAIL rst_mid_fields: got %h/%h exp 0/0", bus.rd_mem, bus.ctrl_mem); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1 || bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_recover: got ready %b busy %b exp 1/0", bus.in_ready, bus.md_busy); end
        drive(OP_SLL, 32'h0000_0003, 32'd36, 32'd0, 1'b0, 5'd2, 5'd0, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.alu_result !== 32'h0000_0030) begin n_fail++; $display("FAIL rst_mid_next_op: got %h exp 30", bus.alu_result); end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_sra_sltu();
        test_alu_random();
        test_muldiv();
        test_flush();
        test_backpressure();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
